to_mont: RTL
============

Name: to_mont

Overview:
- Sequential converter that maps an ordinary residue a (0 <= a < n) into Montgomery form: a_mont = (a * R) mod n, with R = 2^K.
- Feeds operands into the Montgomery product stage, which requires both inputs already in Montgomery form. It is the entry-side counterpart of that stage.
- Radix-2 shift-and-subtract, one bit per clock. Uses no multiplier.
- Valid/ready handshake on both the input side and the output side.

Parameters:
- K, 8: operand and modulus width in bits; R = 2^K.
- CW, $clog2(K+1): iteration-counter width (derived; not overridden).

Ports:
- clk, input, 1: single system clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: a and n are valid this cycle.
- in_ready, output, 1: block can accept a new operand (high only in IDLE).
- a, input, K: residue to convert; must satisfy a < n.
- n, input, K: odd modulus, n > 1.
- out_valid, output, 1: result and err are valid.
- out_ready, input, 1: consumer takes the result this cycle.
- a_mont, output, K: (a * 2^K) mod n; 0 when err = 1.
- err, output, 1: operand rejected (n even, n <= 1, or a >= n).

Behaviour:
- Reset (async assert, any state): state=IDLE, in_ready=1, out_valid=0, a_mont=0, err=0, internal accumulator x=0, counter=0. Reset asserted mid-conversion aborts it with no output.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch a and n.
  - If n[0]=0, or n <= 1, or a >= n: go to DONE with err=1, a_mont=0 (rejection latency 1 cycle).
  - Otherwise: x <= {1'b0, a}, cnt <= 0, go to RUN.
- RUN:
  - in_ready=0; in_valid is ignored and inputs are not sampled.
  - Each cycle: d = 2x (K+1 bits); x <= (d >= n) ? d - n : d; cnt <= cnt + 1.
  - Invariant: x < n, so d <= 2n - 2 < 2^(K+1); a K+1-bit datapath is sufficient, with no overflow.
  - After the K-th step (cnt == K-1 at that edge): a_mont <= x_next[K-1:0], err <= 0, go to DONE.
- DONE:
  - out_valid=1; a_mont and err are held stable until the handshake.
  - On out_ready: out_valid <= 0, go to IDLE.
  - out_ready held low holds the output indefinitely (back-pressure).
  - No new operand is accepted while in DONE.
- Latency (valid case): accept edge + K RUN edges; out_valid rises K+1 cycles after the accepting edge. Throughput is one conversion per K+2 cycles minimum.
- a = 0 is legal and yields a_mont=0, err=0 after the full K cycles (no early exit).
- in_valid and out_ready high in the same cycle while in DONE: the output handshake completes. The input is not taken until the following IDLE cycle.
- Outputs are registered; no combinational path from inputs to outputs except in_ready, which is decoded from state.

Decomposition:
- Shared package rsa_pkg:
  - state enum (IDLE, RUN, DONE);
  - default K constant shared with the Montgomery product stage and the exponentiator;
  - helper function for CW.
- One natural sub-module, mod_dbl_step: combinational; input x (K+1 bits) and n; output (2x >= n ? 2x - n : 2x). It is reusable by a future Montgomery-to-normal or R^2 precompute block.

Test Plan:
- K=8, n=13, a=5 -> after K+1 cycles out_valid=1, a_mont=6 (5*256 = 1280, 1280 mod 13 = 6), err=0.
- K=8, n=13, a=1 -> a_mont=9 (256 mod 13). a=0 -> a_mont=0, with the same K+1-cycle latency.
- K=8, n=255, a=254 -> a_mont=254 (R mod 255 = 1). Exercises max-width subtract/carry.
- Rejection cases, each -> out_valid one cycle after accept, err=1, a_mont=0:
  - n=12, a=3 (even modulus);
  - n=13, a=13 (a >= n);
  - n=1, a=0 (n <= 1).
- Back-pressure: hold out_ready=0 for 20 cycles after done -> out_valid and a_mont stable, in_ready=0, a new in_valid is ignored. Then pulse out_ready -> return to IDLE and accept the next operand.
- Assert rst at RUN cycle 4 -> all outputs 0 and in_ready=1 immediately (async). A new conversion after deassert is correct: n=13, a=5 -> 6.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA datapath blocks
// (Montgomery conversion, Montgomery product, exponentiator).
package rsa_pkg;

    localparam int DEFAULT_K = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Counter wide enough to hold every value from 0 to k inclusive.
    function automatic int cnt_width(input int k);
        return $clog2(k + 1);
    endfunction

endpackage

// File: rtl/to_mont_if.sv
// Operand/result handshake bundle for the normal-to-Montgomery converter.
interface to_mont_if
    import rsa_pkg::*;
#(
    parameter int K = DEFAULT_K
);
    logic         in_valid;
    logic         in_ready;
    logic [K-1:0] a;
    logic [K-1:0] n;
    logic         out_valid;
    logic         out_ready;
    logic [K-1:0] a_mont;
    logic         err;

    modport master (
        output in_valid, a, n, out_ready,
        input  in_ready, out_valid, a_mont, err
    );

    modport slave (
        input  in_valid, a, n, out_ready,
        output in_ready, out_valid, a_mont, err
    );
endinterface

// File: rtl/mod_dbl_step.sv
// One modular doubling step: y = (2x >= n) ? 2x - n : 2x.
// Assumes x < n, so the doubled value always fits in K+1 bits.
module mod_dbl_step #(
    parameter int K = 8
) (
    input  logic [K:0]   x,
    input  logic [K-1:0] n,
    output logic [K:0]   y
);
    logic [K:0] d;
    logic [K:0] n_ext;

    assign d     = x << 1;
    assign n_ext = {1'b0, n};
    assign y     = (d >= n_ext) ? (d - n_ext) : d;
endmodule

// File: rtl/to_mont.sv
// Converts a residue a < n into Montgomery form (a * 2^K) mod n by K
// successive modular doublings, one per clock, behind valid/ready handshakes.
module to_mont
    import rsa_pkg::*;
#(
    parameter int K = DEFAULT_K
) (
    input  logic     clk,
    input  logic     rst,
    to_mont_if.slave bus
);
    localparam int CW = cnt_width(K);

    state_t        state;
    state_t        state_next;
    logic [K:0]    x;
    logic [K:0]    x_next;
    logic [K-1:0]  n_reg;
    logic [CW-1:0] cnt;
    logic [K-1:0]  a_mont_reg;
    logic          err_reg;
    logic          bad_op;
    logic          last_step;

    assign bad_op    = !bus.n[0] || (bus.n <= K'(1)) || (bus.a >= bus.n);
    assign last_step = (cnt == CW'(K - 1));

    mod_dbl_step #(.K(K)) u_step (
        .x (x),
        .n (n_reg),
        .y (x_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (bus.in_valid) state_next = bad_op ? DONE : RUN;
            RUN:  if (last_step)    state_next = DONE;
            DONE: if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Rejected operands skip RUN entirely and report err with a zero result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x          <= '0;
            n_reg      <= '0;
            cnt        <= '0;
            a_mont_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        n_reg      <= bus.n;
                        cnt        <= '0;
                        a_mont_reg <= '0;
                        if (bad_op) begin
                            x       <= '0;
                            err_reg <= 1'b1;
                        end else begin
                            x       <= {1'b0, bus.a};
                            err_reg <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    x   <= x_next;
                    cnt <= cnt + CW'(1);
                    if (last_step) begin
                        a_mont_reg <= x_next[K-1:0];
                        err_reg    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.a_mont    = a_mont_reg;
    assign bus.err       = err_reg;
endmodule
